// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start(0), DATA_W bits LSB-first, stop(1), idle high.
// Latency: start bit on the cycle after accept; tx_ready only in IDLE, so the source holds tx_valid until accepted.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_out_q, tx_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next state so the line changes on the same edge as the state.
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      default: tx_out_d = 1'b1;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_out   = tx_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: a CLKS_PER_BIT=4 instance and a CLKS_PER_BIT=1 instance.
module tb_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_valid, a_ready, a_out, a_busy, a_done;
  logic [7:0] a_data;
  logic       b_rst, b_valid, b_ready, b_out, b_busy, b_done;
  logic [7:0] b_data;

  int n_checks = 0;
  int n_errors = 0;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .rst(a_rst), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_out(a_out), .busy(a_busy), .done(a_done)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_b (
    .clk(clk), .rst(b_rst), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_out(b_out), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k, input int cpb);
    int p;
    p = (k - 1) / cpb;
    if (p == 0) return 1'b0;
    if (p <= 8) return d[p-1];
    return 1'b1;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      a_valid = v;
      a_data  = d;
    end else begin
      b_valid = v;
      b_data  = d;
    end
  endtask

  function automatic logic [3:0] outs(input int sel);
    // {tx_out, busy, done, tx_ready}
    if (sel == 0) return {a_out, a_busy, a_done, a_ready};
    return {b_out, b_busy, b_done, b_ready};
  endfunction

  // Starts at a negedge with the instance idle; returns in the done cycle.
  task automatic run_frame(input int sel, input logic [7:0] d, input logic hold,
                           input logic [7:0] nd, input logic pulse);
    int cpb;
    int len;
    logic [3:0] o;
    cpb = (sel == 0) ? 4 : 1;
    len = 10 * cpb;
    drive(sel, 1'b1, d);
    o = outs(sel);
    check("ready_before_accept", {31'd0, o[0]}, 32'd1);
    @(negedge clk);
    drive(sel, hold, hold ? nd : ~d);
    for (int k = 1; k <= len; k++) begin
      if (pulse && k == len / 2) drive(sel, 1'b1, 8'h3C);
      if (pulse && k == len / 2 + 1) drive(sel, 1'b0, 8'h77);
      o = outs(sel);
      check($sformatf("tx_out d=%0h k=%0d", d, k), {31'd0, o[3]}, {31'd0, exp_bit(d, k, cpb)});
      check($sformatf("busy k=%0d", k), {31'd0, o[2]}, 32'd1);
      check($sformatf("done k=%0d", k), {31'd0, o[1]}, 32'd0);
      check($sformatf("ready k=%0d", k), {31'd0, o[0]}, 32'd0);
      @(negedge clk);
    end
    o = outs(sel);
    check("done_cycle_out", {28'd0, o}, 32'b1011);
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;   // valid during reset must be ignored
    a_data = 8'hEE; b_data = 8'hEE;
    repeat (2) @(negedge clk);
    check("reset_a", {28'd0, outs(0)}, 32'b1001);
    check("reset_b", {28'd0, outs(1)}, 32'b1001);
    a_valid = 1'b0; b_valid = 1'b0;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle_a", {28'd0, outs(0)}, 32'b1001);

    // Single frame 0xA5, done pulses only once
    run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("done_drops", {31'd0, a_done}, 32'd0);
    check("idle_after_done", {28'd0, outs(0)}, 32'b1001);

    // Back-to-back: 0x00 then queued 0xFF accepted in the done cycle
    run_frame(0, 8'h00, 1'b1, 8'hFF, 1'b0);
    run_frame(0, 8'hFF, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    // Valid pulse while busy must not be captured
    run_frame(0, 8'h96, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("no_capture_idle", {28'd0, outs(0)}, 32'b1001);

    // Reset during data bit 3 of 0x5A (cycles 17..20)
    drive(0, 1'b1, 8'h5A);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("abort_frame k=%0d", k), {31'd0, a_out}, {31'd0, exp_bit(8'h5A, k, 4)});
      @(negedge clk);
    end
    a_rst = 1'b1;
    @(negedge clk);
    check("midreset_outs", {28'd0, outs(0)}, 32'b1001);
    a_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("after_abort k=%0d", k), {28'd0, outs(0)}, 32'b1001);
    end
    run_frame(0, 8'h81, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    // CLKS_PER_BIT=1 instance: 10-cycle frame of 0xC3
    run_frame(1, 8'hC3, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("b_done_drops", {31'd0, b_done}, 32'd0);

    // Long idle: line stays high, ready stays high, no done
    for (int k = 0; k < 50; k++) begin
      check($sformatf("idle k=%0d", k), {28'd0, outs(0)}, 32'b1001);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
